// File: rtl/eeprom_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// eeprom_sweep_ctrl_if : start/done handshake and data bus to the I2C EEPROM engine
// Revision : 1.0
// ============================================================================
interface eeprom_sweep_ctrl_if;
  logic [1:0] start_sig;
  logic [7:0] addr_sig;
  logic [7:0] wrdata;
  logic [7:0] rddata;
  logic       done_sig;

  modport master (
    output start_sig,
    output addr_sig,
    output wrdata,
    input  rddata,
    input  done_sig
  );

  modport slave (
    input  start_sig,
    input  addr_sig,
    input  wrdata,
    output rddata,
    output done_sig
  );
endinterface
`default_nettype wire

// File: rtl/eeprom_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// eeprom_sweep_ctrl : write/read-back sweep over an EEPROM address window, with results shown on a tube display
// Revision : 1.0
// ============================================================================
module eeprom_sweep_ctrl #(
  parameter int unsigned DWELL_CYC = 50_000_000,
  parameter logic [7:0]  ADDR_BASE = 8'h00,
  parameter int unsigned NUM_ADDR  = 4,
  parameter logic [7:0]  DATA_SEED = 8'hA7,
  parameter logic [7:0]  DATA_STEP = 8'h11
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                mode,
  eeprom_sweep_ctrl_if.master bus,
  output logic [23:0]         number_sig,
  output logic [7:0]          err_cnt,
  output logic [7:0]          pass_cnt,
  output logic                mismatch
);

  localparam int unsigned    DCW        = $clog2(DWELL_CYC + 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYC - 1);
  localparam logic [7:0]     IDX_LAST   = 8'(NUM_ADDR - 1);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_WR   = 3'd1,
    ST_GAP  = 3'd2,
    ST_RD   = 3'd3,
    ST_SHOW = 3'd4,
    ST_NEXT = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [7:0]     idx, idx_nxt;
  logic           mode_q, mode_q_nxt;
  logic [DCW-1:0] dwell, dwell_nxt;
  logic [1:0]     start_q, start_nxt;
  logic [7:0]     addr_q, addr_nxt;
  logic [7:0]     wrdata_q, wrdata_nxt;
  logic [23:0]    number_nxt;
  logic [7:0]     err_nxt;
  logic [7:0]     pass_nxt;
  logic           mismatch_nxt;
  logic [7:0]     pat_base;
  logic [7:0]     exp_pat;

  assign bus.start_sig = start_q;
  assign bus.addr_sig  = addr_q;
  assign bus.wrdata    = wrdata_q;

  // Odd passes use the inverted pattern so every cell sees both polarities.
  assign pat_base = DATA_SEED + idx * DATA_STEP;
  assign exp_pat  = pat_base ^ {8{pass_cnt[0]}};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      idx        <= 8'h00;
      mode_q     <= 1'b0;
      dwell      <= '0;
      start_q    <= 2'b00;
      addr_q     <= ADDR_BASE;
      wrdata_q   <= 8'h00;
      number_sig <= 24'h000000;
      err_cnt    <= 8'h00;
      pass_cnt   <= 8'h00;
      mismatch   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      mode_q     <= mode_q_nxt;
      dwell      <= dwell_nxt;
      start_q    <= start_nxt;
      addr_q     <= addr_nxt;
      wrdata_q   <= wrdata_nxt;
      number_sig <= number_nxt;
      err_cnt    <= err_nxt;
      pass_cnt   <= pass_nxt;
      mismatch   <= mismatch_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    mode_q_nxt   = mode_q;
    dwell_nxt    = dwell;
    start_nxt    = start_q;
    addr_nxt     = addr_q;
    wrdata_nxt   = wrdata_q;
    number_nxt   = number_sig;
    err_nxt      = err_cnt;
    pass_nxt     = pass_cnt;
    mismatch_nxt = 1'b0;

    case (state)
      ST_LOAD: begin
        mode_q_nxt = mode;
        addr_nxt   = ADDR_BASE + idx;
        wrdata_nxt = exp_pat;
        if (mode) begin
          start_nxt = 2'b10;
          state_nxt = ST_RD;
        end else begin
          start_nxt = 2'b01;
          state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        if (bus.done_sig) begin
          start_nxt = 2'b00;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        start_nxt = 2'b10;
        state_nxt = ST_RD;
      end
      ST_RD: begin
        // The low display byte doubles as the captured read-back value.
        if (bus.done_sig) begin
          start_nxt  = 2'b00;
          number_nxt = {addr_q, (mode_q ? 8'h00 : wrdata_q), bus.rddata};
          if (!mode_q && (bus.rddata != wrdata_q)) begin
            mismatch_nxt = 1'b1;
            if (err_cnt != 8'hFF) begin
              err_nxt = err_cnt + 8'd1;
            end
          end
          dwell_nxt = '0;
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          state_nxt = ST_NEXT;
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      ST_NEXT: begin
        if (idx == IDX_LAST) begin
          idx_nxt  = 8'h00;
          pass_nxt = pass_cnt + 8'd1;
        end else begin
          idx_nxt = idx + 8'd1;
        end
        state_nxt = ST_LOAD;
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

endmodule
`default_nettype wire
